// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the pipeline slice.
// Contents: opcode/funct constants, datapath and register-address widths,
// and a helper that picks the destination register field out of an instruction.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;

    // R-type writes rd, the I-type forms write rt.
    function automatic logic [REG_ADDR_W-1:0] dest_reg(input logic [31:0] ir);
        return (ir[31:26] == OP_RTYPE) ? ir[15:11] : ir[20:16];
    endfunction

endpackage

// File: rtl/mips_data_mem.sv
// Single-port synchronous data RAM, read-first.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable: mem[addr] <= wdata
//   re    - read enable: rdata <= mem[addr] (old contents on a same-edge write)
//   addr  - word address, DEPTH_LOG2 bits
//   wdata - write data
//   rdata - registered read data; holds its value while re=0
// Contents are never reset.
module mips_data_mem #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips_mem_wb_stage.sv
// MEM stage of the 5-stage MIPS pipeline, producing registered write-back
// controls for the register bank.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   stall             - hold the stage: nothing sampled, nothing written
//   ex_valid, ex_ir   - EX/MEM latch valid flag and instruction
//   ex_alu            - ALU result (byte address for lw/sw)
//   ex_rt             - store data
//   wb_en/rd/data/ir  - write-back controls, one cycle after sampling
//   mem_err           - sticky misaligned lw/sw flag, cleared only by rst
//   ld_count/st_count - saturating load/store counters, present only when
//                       MEM_STAGE_STATS_EN is defined
module mips_mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_ir,
    input  logic [DATA_W-1:0]     ex_alu,
    input  logic [DATA_W-1:0]     ex_rt,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic [31:0]           wb_ir,
`ifdef MEM_STAGE_STATS_EN
    output logic [15:0]           ld_count,
    output logic [15:0]           st_count,
`endif
    output logic                  mem_err
);

    logic [5:0]            opcode, funct;
    logic                  is_rtype_alu, is_addi, is_lw, is_sw;
    logic                  misaligned;
    logic [REG_ADDR_W-1:0] dest;
    logic                  mem_we, mem_re;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  wb_en_d,   wb_en_q;
    logic [REG_ADDR_W-1:0] wb_rd_d,   wb_rd_q;
    logic [DATA_W-1:0]     alu_d,     alu_q;
    logic [31:0]           wb_ir_d,   wb_ir_q;
    logic                  is_load_d, is_load_q;
    logic                  mem_err_d, mem_err_q;

    always_comb begin
        opcode       = ex_ir[31:26];
        funct        = ex_ir[5:0];
        is_rtype_alu = (opcode == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB));
        is_addi      = (opcode == OP_ADDI);
        is_lw        = (opcode == OP_LW);
        is_sw        = (opcode == OP_SW);
        misaligned   = (ex_alu[1:0] != 2'b00);
        dest         = dest_reg(ex_ir);
        // Reset and stall both block the RAM; a misaligned access never touches it.
        mem_we       = !rst && !stall && ex_valid && is_sw && !misaligned;
        mem_re       = !rst && !stall && ex_valid && is_lw && !misaligned;
    end

    mips_data_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_data_mem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (ex_alu[DEPTH_LOG2+1:2]),
        .wdata (ex_rt),
        .rdata (mem_rdata)
    );

    always_comb begin
        wb_en_d   = wb_en_q;
        wb_rd_d   = wb_rd_q;
        alu_d     = alu_q;
        wb_ir_d   = wb_ir_q;
        is_load_d = is_load_q;
        mem_err_d = mem_err_q;
        if (rst) begin
            wb_en_d   = 1'b0;
            wb_rd_d   = '0;
            alu_d     = '0;
            wb_ir_d   = '0;
            is_load_d = 1'b0;
            mem_err_d = 1'b0;
        end else if (!stall) begin
            wb_en_d   = ex_valid && (is_rtype_alu || is_addi || (is_lw && !misaligned))
                        && (dest != '0);
            wb_rd_d   = dest;
            alu_d     = is_sw ? '0 : ex_alu;
            wb_ir_d   = ex_ir;
            // Only a load that actually read the RAM may select it on the mux.
            is_load_d = mem_re;
            if (ex_valid && (is_lw || is_sw) && misaligned) begin
                mem_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        wb_en_q   <= wb_en_d;
        wb_rd_q   <= wb_rd_d;
        alu_q     <= alu_d;
        wb_ir_q   <= wb_ir_d;
        is_load_q <= is_load_d;
        mem_err_q <= mem_err_d;
    end

    assign wb_en   = wb_en_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = is_load_q ? mem_rdata : alu_q;
    assign wb_ir   = wb_ir_q;
    assign mem_err = mem_err_q;

`ifdef MEM_STAGE_STATS_EN
    logic [15:0] ld_count_d, ld_count_q;
    logic [15:0] st_count_d, st_count_q;

    always_comb begin
        ld_count_d = ld_count_q;
        st_count_d = st_count_q;
        if (rst) begin
            ld_count_d = '0;
            st_count_d = '0;
        end else begin
            if (mem_re && (ld_count_q != 16'hFFFF)) begin
                ld_count_d = ld_count_q + 16'd1;
            end
            if (mem_we && (st_count_q != 16'hFFFF)) begin
                st_count_d = st_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        ld_count_q <= ld_count_d;
        st_count_q <= st_count_d;
    end

    assign ld_count = ld_count_q;
    assign st_count = st_count_q;
`endif

endmodule

// File: tb/tb_mips_mem_wb_stage.sv
module tb_mips_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_ir = '0;
    logic [31:0] ex_alu = '0;
    logic [31:0] ex_rt = '0;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] wb_ir;
    logic        mem_err;
`ifdef MEM_STAGE_STATS_EN
    logic [15:0] ld_count, st_count;
    int unsigned m_ld, m_st;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: what the write-back outputs should show now.
    logic [31:0] m_mem [int];
    logic        m_en, m_err, m_data_chk;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_ir;

    always #5 clk = ~clk;

    mips_mem_wb_stage #(
        .DEPTH_LOG2 (10),
        .DATA_W     (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .ex_valid (ex_valid),
        .ex_ir    (ex_ir),
        .ex_alu   (ex_alu),
        .ex_rt    (ex_rt),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .wb_ir    (wb_ir),
`ifdef MEM_STAGE_STATS_EN
        .ld_count (ld_count),
        .st_count (st_count),
`endif
        .mem_err  (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rd, input logic [5:0] fn);
        return {6'b000000, 5'd1, 5'd2, rd[4:0], 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rt);
        return {op, 5'd1, rt[4:0], 16'h0000};
    endfunction

    // Apply one cycle of inputs, advance the model by the ISA rules and compare.
    task automatic step(input logic r, input logic s, input logic v, input logic [31:0] ir,
                        input logic [31:0] alu, input logic [31:0] rt);
        logic [5:0] op, fn;
        logic       arith, lw, sw, mis;
        int         idx;
        logic [4:0] dst;
        rst = r; stall = s; ex_valid = v; ex_ir = ir; ex_alu = alu; ex_rt = rt;
        @(posedge clk);
        #1;
        if (r) begin
            m_en = 0; m_rd = 0; m_data = 0; m_ir = 0; m_err = 0; m_data_chk = 1;
`ifdef MEM_STAGE_STATS_EN
            m_ld = 0; m_st = 0;
`endif
        end else if (!s) begin
            op    = ir[31:26];
            fn    = ir[5:0];
            arith = (op == 6'd0 && (fn == 6'd32 || fn == 6'd34)) || op == 6'd8;
            lw    = (op == 6'd35);
            sw    = (op == 6'd43);
            mis   = (alu % 4) != 0;
            idx   = int'((alu / 4) % 1024);
            dst   = (op == 6'd0) ? ir[15:11] : ir[20:16];
            m_ir  = ir;
            m_rd  = dst;
            m_en  = v && (arith || (lw && !mis)) && dst != 0;
            if (v && (lw || sw) && mis) m_err = 1;
            m_data_chk = m_en;
            if (sw) begin
                m_data = 0;
                m_data_chk = v && !mis;
                if (v && !mis) begin
                    m_mem[idx] = rt;
`ifdef MEM_STAGE_STATS_EN
                    if (m_st < 65535) m_st++;
`endif
                end
            end else if (lw && v && !mis) begin
                m_data_chk = m_en && m_mem.exists(idx);
                m_data = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
`ifdef MEM_STAGE_STATS_EN
                if (m_ld < 65535) m_ld++;
`endif
            end else begin
                m_data = alu;
            end
        end
        check("wb_en", {31'd0, wb_en}, {31'd0, m_en});
        check("wb_ir", wb_ir, m_ir);
        check("mem_err", {31'd0, mem_err}, {31'd0, m_err});
        if (m_en) check("wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
        if (m_data_chk) check("wb_data", wb_data, m_data);
`ifdef MEM_STAGE_STATS_EN
        check("ld_count", {16'd0, ld_count}, m_ld);
        check("st_count", {16'd0, st_count}, m_st);
`endif
    endtask

    initial begin
        logic [31:0] ir, alu;
        int          k;

        // Reset held for two cycles.
        step(1, 0, 0, '0, '0, '0);
        step(1, 0, 0, '0, '0, '0);
        check("rst_wb_data", wb_data, 32'h0);

        // Store then load of the same word on consecutive edges.
        step(0, 0, 1, i_ins(6'd43, 7), 32'h10, 32'hDEADBEEF);
        step(0, 0, 1, i_ins(6'd35, 5), 32'h10, 32'h0);
        check("raw_data", wb_data, 32'hDEADBEEF);
        check("raw_rd", {27'd0, wb_rd}, 32'd5);

        // Reset on the edge that samples a load.
        step(1, 0, 1, i_ins(6'd35, 5), 32'h10, 32'h0);
        check("rst_mid_lw", {31'd0, wb_en}, 32'd0);

        // ALU pass-through, then rd=0 is suppressed.
        step(0, 0, 1, r_ins(3, 6'd32), 32'd7, 32'h0);
        check("add_data", wb_data, 32'd7);
        step(0, 0, 1, r_ins(0, 6'd32), 32'd7, 32'h0);
        check("add_rd0", {31'd0, wb_en}, 32'd0);

        // Misaligned store: no write, sticky error.
        step(0, 0, 1, i_ins(6'd43, 7), 32'h12, 32'h12345678);
        step(0, 0, 1, i_ins(6'd35, 6), 32'h10, 32'h0);
        check("mis_keep", wb_data, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, i_ins(6'd8, i + 1), 32'(i * 3), 32'h0);
        end
        check("err_sticky", {31'd0, mem_err}, 32'd1);
        step(1, 0, 0, '0, '0, '0);

        // Stall across a load; a stalled store must not land either.
        step(0, 0, 1, i_ins(6'd43, 1), 32'h20, 32'hCAFEF00D);
        step(0, 0, 1, r_ins(9, 6'd34), 32'h55, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, i_ins(6'd35, 4), 32'h20, 32'h0);
        end
        check("stall_frozen", wb_data, 32'h55);
        step(0, 1, 1, i_ins(6'd43, 1), 32'h20, 32'h11111111);
        step(0, 0, 1, i_ins(6'd35, 4), 32'h20, 32'h0);
        check("stall_load", wb_data, 32'hCAFEF00D);
        step(0, 1, 1, i_ins(6'd43, 1), 32'h21, 32'h0);
        check("stall_no_err", {31'd0, mem_err}, 32'd0);

        // Address wrap and invalid store.
        step(0, 0, 1, i_ins(6'd43, 1), 32'h1004, 32'hA5A5_0001);
        step(0, 0, 1, i_ins(6'd35, 8), 32'h4, 32'h0);
        check("wrap", wb_data, 32'hA5A5_0001);
        step(0, 0, 0, i_ins(6'd43, 1), 32'h4, 32'hBBBB_BBBB);
        step(0, 0, 1, i_ins(6'd35, 8), 32'h4, 32'h0);
        check("inval_sw", wb_data, 32'hA5A5_0001);

        // Random mix against the model.
        for (int n = 0; n < 600; n++) begin
            k = int'($urandom_range(0, 9));
            case (k)
                0, 1:    ir = r_ins(int'($urandom_range(0, 31)), ($urandom_range(0, 1) != 0) ? 6'd32 : 6'd34);
                2:       ir = i_ins(6'd8, int'($urandom_range(0, 31)));
                3, 4, 5: ir = i_ins(6'd35, int'($urandom_range(0, 31)));
                6, 7:    ir = i_ins(6'd43, int'($urandom_range(0, 31)));
                8:       ir = r_ins(int'($urandom_range(1, 31)), 6'($urandom_range(0, 63)));
                default: ir = $urandom;
            endcase
            alu = {$urandom_range(0, 255) << 12} | ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 19) == 0) alu = alu | 32'($urandom_range(1, 3));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) != 0, ir, alu, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mem_wb_stage.md
Name: mips_mem_wb_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of the execute stage and upstream of the register-bank write port.
- Consumes the EX/MEM latch: instruction, ALU result, forwarded rt value.
- Performs word load/store on an internal synchronous data memory.
- Produces registered write-back controls for the register bank: data, destination, enable.

Parameters:
- DEPTH_LOG2, 10, data memory word-address width (1024 words).
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold stage: no sampling, no memory write, outputs frozen.
- ex_valid  in  1  EX/MEM latch holds a real instruction.
- ex_ir  in  32  instruction word from execute.
- ex_alu  in  32  ALU result: byte address for lw/sw, result otherwise.
- ex_rt  in  32  rt register value (store data).
- wb_en  out  1  register-bank write enable.
- wb_rd  out  5  destination register.
- wb_data  out  32  write-back value.
- wb_ir  out  32  instruction now in write-back (debug/hazard use).
- mem_err  out  1  sticky misaligned-access flag.

Behaviour:
- Reset (rst=1 at an edge):
  - wb_en=0, wb_rd=0, wb_data=0, wb_ir=0, mem_err=0, internal is_load_q=0.
  - Memory contents are not cleared.
  - Reset dominates stall.
- Decode of ex_ir:
  - R-type: opcode 000000. add funct 100000, sub funct 100010.
  - addi: opcode 001000.
  - lw: opcode 100011.
  - sw: opcode 101011.
  - Anything else is a no-op: no write, wb_en=0.
- Destination: rd = ex_ir[15:11] for R-type; ex_ir[20:16] for addi/lw.
- Address:
  - word index = ex_alu[DEPTH_LOG2+1:2].
  - Upper bits are ignored; addresses wrap modulo 4 KiB.
  - misaligned = ex_alu[1:0] != 0.
- Latency: 1 cycle. Inputs sampled at edge N (stall=0); wb_* valid after edge N until the next non-stalled edge.
- sw, valid and aligned: memory[index] <= ex_rt at edge N. wb_en=0, wb_data=0.
- lw: synchronous RAM read at edge N; is_load_q registered.
- wb_data mux: memory read data when is_load_q=1, else registered ALU value.
- Read-after-write: sw at edge N followed by lw of the same address at edge N+1 returns the new data. Two memory operations never share an edge.
- wb_en=1 after edge N iff all hold at N:
  - ex_valid=1,
  - the instruction is add, sub, addi or lw,
  - rd != 0,
  - not a misaligned lw.
- Misaligned lw/sw: store suppressed, wb_en=0, mem_err set. mem_err stays set until rst.
- ex_valid=0: no memory write. wb_en=0 after the edge. wb_ir still latches ex_ir.
- stall=1: no memory write, no RAM read-enable, all outputs and is_load_q hold. mem_err cannot newly set.
- stall and a misaligned access together: the access is ignored until stall drops.

Optional Feature:
- Macro: MEM_STAGE_STATS_EN.
- Defined: adds outputs ld_count and st_count, 16 bits each.
  - Reset to 0.
  - Increment on each non-stalled, valid, aligned lw and sw respectively.
  - Saturate at 16'hFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW.
  - funct constants FN_ADD, FN_SUB.
  - DATA_W, and a REG_ADDR_W=5 constant.
- One sub-module mips_data_mem:
  - single-port synchronous RAM, read-first.
  - ports: clk, we, re, addr[DEPTH_LOG2-1:0], wdata, rdata.
  - rdata is registered and holds when re=0.

Test Plan:
- Reset: after rst=1 for 2 cycles, all outputs 0 and mem_err=0. rst asserted mid-lw clears wb_en on the same edge.
- Store then load: sw ex_alu=0x10, ex_rt=0xDEADBEEF; next cycle lw rt=5, ex_alu=0x10 -> wb_en=1, wb_rd=5, wb_data=0xDEADBEEF.
- ALU pass-through: add rd=3, ex_alu=7 -> wb_en=1, wb_rd=3, wb_data=7. Same with rd=0 -> wb_en=0.
- Misaligned: sw ex_alu=0x12 -> memory unchanged (lw 0x10 returns prior value), mem_err=1. mem_err stays 1 through 5 further valid instructions.
- Stall: assert stall during lw with ex_alu=0x20 for 3 cycles -> outputs frozen at the prior instruction, no write. After release, load completes 1 cycle later.
- Wrap and invalid:
  - sw ex_alu=0x1004 aliases word 1; lw ex_alu=0x4 returns the stored data.
  - sw with ex_valid=0 leaves memory unchanged.
